// File: rtl/snake_pkg.sv
// Shared snake-game constants and the food placement state encoding.
package snake_pkg;

  localparam int unsigned COORD_W    = 10;
  localparam int unsigned GRID_PITCH = 18;
  localparam int unsigned GRID_ORG   = 12;

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    ACTIVE = 2'd3
  } food_state_t;

endpackage

// File: rtl/grid_align_check.sv
// Combinational test that one coordinate sits on a cell origin inside the field.
module grid_align_check
  import snake_pkg::*;
#(
  parameter int unsigned COORD_W   = snake_pkg::COORD_W,
  parameter int unsigned FIELD_MAX = 606
) (
  input  logic [COORD_W-1:0] i_coord,
  output logic               o_on_grid
);

  logic [COORD_W-1:0] w_offset;

  // Offset from the grid origin must be a whole number of cell pitches.
  always_comb begin
    w_offset  = i_coord - COORD_W'(GRID_ORG);
    o_on_grid = (i_coord >= COORD_W'(GRID_ORG)) &&
                (i_coord <= COORD_W'(FIELD_MAX)) &&
                ((w_offset % COORD_W'(GRID_PITCH)) == '0);
  end

endmodule

// File: rtl/food_eater.sv
// Food placement and eat detection for the snake game.
// Optional build macro FOOD_GRID_CHECK_EN: also reject off-grid or out-of-field
// generator positions during CHECK.
module food_eater
  import snake_pkg::*;
#(
  parameter int unsigned COORD_W    = snake_pkg::COORD_W,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned RETRY_MAX  = 7,
  parameter int unsigned SCORE_W    = 10,
  parameter int unsigned FIELD_MAX  = 606
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  input  logic [COORD_W-1:0] box_x,
  input  logic [COORD_W-1:0] box_y,
  input  logic               occupied,
  output logic               drive,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic               food_valid,
  output logic               grow,
  output logic [SCORE_W-1:0] score,
  output logic               retry_fail
);

  localparam int unsigned CNT_W     = 4;
  localparam int unsigned FOOD_INIT = 12;

  food_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_settle, w_settle_nxt;
  logic [CNT_W-1:0]   r_retry, w_retry_nxt;
  logic               r_drive, w_drive_nxt;
  logic               r_grow, w_grow_nxt;
  logic               r_food_valid, w_food_valid_nxt;
  logic [COORD_W-1:0] r_food_x, w_food_x_nxt;
  logic [COORD_W-1:0] r_food_y, w_food_y_nxt;
  logic [SCORE_W-1:0] r_score, w_score_nxt;
  logic               r_retry_fail, w_retry_fail_nxt;
  logic               w_reject;
  logic               w_hit;

`ifdef FOOD_GRID_CHECK_EN
  logic w_x_on_grid;
  logic w_y_on_grid;

  grid_align_check #(.COORD_W(COORD_W), .FIELD_MAX(FIELD_MAX)) u_grid_x (
    .i_coord   (box_x),
    .o_on_grid (w_x_on_grid)
  );

  grid_align_check #(.COORD_W(COORD_W), .FIELD_MAX(FIELD_MAX)) u_grid_y (
    .i_coord   (box_y),
    .o_on_grid (w_y_on_grid)
  );

  assign w_reject = occupied | ~(w_x_on_grid & w_y_on_grid);
`else
  logic w_unused_field;

  assign w_unused_field = ^COORD_W'(FIELD_MAX);
  assign w_reject       = occupied;
`endif

  assign w_hit = step && (head_x == r_food_x) && (head_y == r_food_y);

  // Next-state and next-output logic for the placement/eat sequence.
  always_comb begin
    w_state_nxt      = r_state;
    w_settle_nxt     = r_settle;
    w_retry_nxt      = r_retry;
    w_drive_nxt      = 1'b0;
    w_grow_nxt       = 1'b0;
    w_food_valid_nxt = r_food_valid;
    w_food_x_nxt     = r_food_x;
    w_food_y_nxt     = r_food_y;
    w_score_nxt      = r_score;
    w_retry_fail_nxt = r_retry_fail;
    unique case (r_state)
      REQ: begin
        w_drive_nxt  = 1'b1;
        w_settle_nxt = CNT_W'(SETTLE_CYC - 1);
        w_state_nxt  = SETTLE;
      end
      SETTLE: begin
        if (r_settle == '0) w_state_nxt = CHECK;
        else                w_settle_nxt = r_settle - CNT_W'(1);
      end
      CHECK: begin
        if (w_reject && (r_retry < CNT_W'(RETRY_MAX))) begin
          w_retry_nxt = r_retry + CNT_W'(1);
          w_state_nxt = REQ;
        end else begin
          if (w_reject) w_retry_fail_nxt = 1'b1;
          w_food_x_nxt = box_x;
          w_food_y_nxt = box_y;
          w_retry_nxt  = '0;
          w_state_nxt  = ACTIVE;
        end
      end
      ACTIVE: begin
        // food_valid rises one cycle after the position is latched
        w_food_valid_nxt = 1'b1;
        if (w_hit) begin
          w_grow_nxt       = 1'b1;
          w_food_valid_nxt = 1'b0;
          if (r_score != '1) w_score_nxt = r_score + SCORE_W'(1);
          w_state_nxt      = REQ;
        end
      end
      default: w_state_nxt = REQ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= REQ;
      r_settle     <= '0;
      r_retry      <= '0;
      r_drive      <= 1'b0;
      r_grow       <= 1'b0;
      r_food_valid <= 1'b0;
      r_food_x     <= COORD_W'(FOOD_INIT);
      r_food_y     <= COORD_W'(FOOD_INIT);
      r_score      <= '0;
      r_retry_fail <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle     <= w_settle_nxt;
      r_retry      <= w_retry_nxt;
      r_drive      <= w_drive_nxt;
      r_grow       <= w_grow_nxt;
      r_food_valid <= w_food_valid_nxt;
      r_food_x     <= w_food_x_nxt;
      r_food_y     <= w_food_y_nxt;
      r_score      <= w_score_nxt;
      r_retry_fail <= w_retry_fail_nxt;
    end
  end

  assign drive      = r_drive;
  assign grow       = r_grow;
  assign food_valid = r_food_valid;
  assign food_x     = r_food_x;
  assign food_y     = r_food_y;
  assign score      = r_score;
  assign retry_fail = r_retry_fail;

endmodule

// File: tb/tb_food_eater.sv
// Directed bench for food_eater with an expected-food and expected-score scoreboard.
module tb_food_eater;

  localparam int unsigned CW = 10;
  localparam int unsigned SW = 10;

  typedef struct {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } pos_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          step;
  logic [CW-1:0] head_x, head_y, box_x, box_y;
  logic          occupied;
  logic          drive, food_valid, grow, retry_fail;
  logic [CW-1:0] food_x, food_y;
  logic [SW-1:0] score;

  int   cyc = -1;
  int   n_chk = 0;
  int   n_pass = 0;
  pos_t exp_food_q[$];
  int   exp_score_q[$];

  food_eater dut (
    .clk        (clk),
    .rst        (rst),
    .step       (step),
    .head_x     (head_x),
    .head_y     (head_y),
    .box_x      (box_x),
    .box_y      (box_y),
    .occupied   (occupied),
    .drive      (drive),
    .food_x     (food_x),
    .food_y     (food_y),
    .food_valid (food_valid),
    .grow       (grow),
    .score      (score),
    .retry_fail (retry_fail)
  );

  always #5 clk = ~clk;

  // cycle 0 is the first rising edge after reset release
  always @(posedge clk) cyc <= rst ? -1 : cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    step = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_drive", 32'(drive), 32'd0);
    chk("rst_valid", 32'(food_valid), 32'd0);
    chk("rst_grow", 32'(grow), 32'd0);
    chk("rst_food_x", 32'(food_x), 32'd12);
    chk("rst_food_y", 32'(food_y), 32'd12);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_retry_fail", 32'(retry_fail), 32'd0);
    rst = 1'b0;
  endtask

  // Serve generator/body-store inputs until food_valid, bounded.
  task automatic place(input int occ_upto, input logic [CW-1:0] x1, input logic [CW-1:0] y1,
                       input logic [CW-1:0] x2, input logic [CW-1:0] y2,
                       output int nd, output int first_drive, output int vcyc);
    nd = 0; first_drive = -1; vcyc = -1;
    occupied = (0 < occ_upto);
    box_x = x1; box_y = y1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (drive === 1'b1) begin
        if (nd == 0) first_drive = cyc;
        nd++;
      end
      occupied = (nd <= occ_upto);
      if (nd <= 1) begin box_x = x1; box_y = y1; end
      else         begin box_x = x2; box_y = y2; end
      if (food_valid === 1'b1) begin
        vcyc = cyc;
        break;
      end
    end
  endtask

  task automatic check_food(input string tag);
    pos_t e;
    e = exp_food_q.pop_front();
    chk({tag, "_valid"}, 32'(food_valid), 32'd1);
    chk({tag, "_food_x"}, 32'(food_x), 32'(e.x));
    chk({tag, "_food_y"}, 32'(food_y), 32'(e.y));
  endtask

  // One-cycle step pulse; compares grow (and score via scoreboard) next cycle.
  task automatic eat(input string tag, input logic [CW-1:0] hx, input logic [CW-1:0] hy,
                     input logic exp_eat, input int exp_score);
    step = 1'b1; head_x = hx; head_y = hy;
    if (exp_eat) exp_score_q.push_back(exp_score);
    @(negedge clk);
    step = 1'b0;
    chk({tag, "_grow"}, 32'(grow), 32'(exp_eat));
    chk({tag, "_valid"}, 32'(food_valid), 32'(!exp_eat));
    if (exp_score_q.size() > 0) chk({tag, "_score"}, 32'(score), 32'(exp_score_q.pop_front()));
    else                        chk({tag, "_score_hold"}, 32'(score), 32'(exp_score));
  endtask

  initial begin
    int nd, fd, vc;
    step = 1'b0; head_x = '0; head_y = '0;
    box_x = 10'd30; box_y = 10'd48; occupied = 1'b0;

    // first-try accept
    do_reset();
    exp_food_q.push_back('{x: 10'd30, y: 10'd48});
    place(-1, 10'd30, 10'd48, 10'd30, 10'd48, nd, fd, vc);
    chk("a_first_drive_cyc", 32'(fd), 32'd0);
    chk("a_valid_cyc", 32'(vc), 32'd4);
    chk("a_drives", 32'(nd), 32'd1);
    check_food("a");

    // two occupied rejects then accept
    do_reset();
    exp_food_q.push_back('{x: 10'd30, y: 10'd48});
    place(2, 10'd30, 10'd48, 10'd30, 10'd48, nd, fd, vc);
    chk("b_drives", 32'(nd), 32'd3);
    chk("b_valid_cyc", 32'(vc), 32'd12);
    chk("b_retry_fail", 32'(retry_fail), 32'd0);
    check_food("b");

    // always occupied: retries exhausted, accepted anyway
    do_reset();
    exp_food_q.push_back('{x: 10'd30, y: 10'd48});
    place(1000, 10'd30, 10'd48, 10'd30, 10'd48, nd, fd, vc);
    chk("c_drives", 32'(nd), 32'd8);
    chk("c_valid_cyc", 32'(vc), 32'd32);
    chk("c_retry_fail", 32'(retry_fail), 32'd1);
    check_food("c");

    // miss then hit; drive follows two cycles after step
    occupied = 1'b0;
    eat("d_miss", 10'd30, 10'd66, 1'b0, 0);
    eat("d_hit", 10'd30, 10'd48, 1'b1, 1);
    @(negedge clk);
    chk("d_grow_single", 32'(grow), 32'd0);
    chk("d_drive_n2", 32'(drive), 32'd1);
    chk("d_retry_fail_sticky", 32'(retry_fail), 32'd1);

    // saturate score
    for (int k = 2; k <= 1024; k++) begin
      exp_food_q.push_back('{x: 10'd30, y: 10'd48});
      place(-1, 10'd30, 10'd48, 10'd30, 10'd48, nd, fd, vc);
      check_food("e");
      eat("e_eat", 10'd30, 10'd48, 1'b1, (k > 1023) ? 1023 : k);
    end
    chk("e_retry_fail_sticky", 32'(retry_fail), 32'd1);

    // off-grid generator position
    do_reset();
`ifdef FOOD_GRID_CHECK_EN
    exp_food_q.push_back('{x: 10'd30, y: 10'd48});
    place(-1, 10'd31, 10'd48, 10'd30, 10'd48, nd, fd, vc);
    chk("f_drives", 32'(nd), 32'd2);
`else
    exp_food_q.push_back('{x: 10'd31, y: 10'd48});
    place(-1, 10'd31, 10'd48, 10'd30, 10'd48, nd, fd, vc);
    chk("f_drives", 32'(nd), 32'd1);
`endif
    check_food("f");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
